// File: rtl/hw_pkg.sv
// Shared constants for the Hack Computer I/O front-end:
// keyboard codes and the default debounce count.
package hw_pkg;

  localparam int DEBOUNCE_DEFAULT = 500000;

  localparam logic [15:0] KEY_NEWLINE = 16'd128;
  localparam logic [15:0] KEY_LEFT    = 16'd130;
  localparam logic [15:0] KEY_RIGHT   = 16'd132;

  // Button index to Hack key code; unmapped buttons give 0.
  function automatic logic [15:0] key_code(input int idx);
    logic [15:0] code;
    case (idx)
      0:       code = KEY_LEFT;
      1:       code = KEY_RIGHT;
      2:       code = KEY_NEWLINE;
      default: code = 16'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// Single-bit 2-flop synchroniser followed by a
// stable-count debouncer.
module debounce_cell
  import hw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count consecutive mismatches; accept the new level at the limit.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CMAX) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, stable level and counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

// File: rtl/key_input_unit.sv
// Conditions DE0 buttons and switches: debounce, press
// pulses and the Hack keyboard word.
module key_input_unit
  import hw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int N_BTN           = 3,
  parameter int N_SW            = 10,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  input  logic [N_SW-1:0]  sw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_SW-1:0]  sw_level,
  output logic [15:0]      kbd_data
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] prev_q;
  logic [N_BTN-1:0] prev_d;

  assign btn_raw = BTN_ACTIVE_LOW ? ~btn : btn;

  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (btn_raw[b]),
      .level_o(btn_level[b])
    );
  end

  for (genvar s = 0; s < N_SW; s++) begin : g_sw
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (sw[s]),
      .level_o(sw_level[s])
    );
  end

  assign prev_d    = btn_level;
  assign btn_press = btn_level & ~prev_q;

  // Previous debounced button level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  // Priority encode held buttons; lowest index wins.
  always_comb begin
    kbd_data = 16'd0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (btn_level[i]) begin
        kbd_data = key_code(i);
      end
    end
  end

endmodule

// File: tb/tb_key_input_unit.sv
// Directed and random checks of key_input_unit against
// a windowed-history reference model.
module tb_key_input_unit;

  localparam int D = 4;

  logic        clk;
  logic        reset;
  logic [2:0]  btn;
  logic [9:0]  sw;
  logic [2:0]  btn_level;
  logic [2:0]  btn_press;
  logic [9:0]  sw_level;
  logic [15:0] kbd_data;

  int total;
  int bad;

  logic [12:0] hist[$];
  logic [12:0] mstable;
  logic [12:0] mprev;

  key_input_unit #(
    .DEBOUNCE_CYCLES(D),
    .N_BTN(3),
    .N_SW(10),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .sw       (sw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .sw_level (sw_level),
    .kbd_data (kbd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mkbd(input logic [2:0] lv);
    if (lv[0])      return 16'd130;
    else if (lv[1]) return 16'd132;
    else if (lv[2]) return 16'd128;
    else            return 16'd0;
  endfunction

  // A level flips once the last D synchronised samples
  // (raw delayed by two edges) all disagree with it.
  task automatic model_edge();
    logic [12:0] raw;
    logic [12:0] smp;
    bit          all;
    int          n;
    raw = {sw, ~btn};
    if (!reset) begin
      hist.delete();
      mstable = '0;
      mprev   = '0;
    end else begin
      mprev = mstable;
      hist.push_back(raw);
      if (hist.size() > D + 2) void'(hist.pop_front());
      n = hist.size();
      for (int b = 0; b < 13; b++) begin
        all = 1'b1;
        for (int k = 0; k < D; k++) begin
          int idx;
          idx = n - 3 - k;
          if (idx < 0) smp[b] = 1'b0;
          else smp[b] = hist[idx][b];
          if (smp[b] == mstable[b]) all = 1'b0;
        end
        if (all) mstable[b] = ~mstable[b];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("btn_level", {13'd0, btn_level}, {13'd0, mstable[2:0]});
    chk("btn_press", {13'd0, btn_press},
        {13'd0, mstable[2:0] & ~mprev[2:0]});
    chk("sw_level", {6'd0, sw_level}, {6'd0, mstable[12:3]});
    chk("kbd_data", kbd_data, mkbd(mstable[2:0]));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int lat;
    int npress;
    int len;
    total   = 0;
    bad     = 0;
    mstable = '0;
    mprev   = '0;
    reset   = 1'b0;
    btn     = 3'b111;
    sw      = 10'h000;

    steps(3);
    chk("rst_kbd", kbd_data, 16'd0);
    reset = 1'b1;
    steps(20);
    chk("idle_press", {13'd0, btn_press}, 16'd0);

    btn = 3'b110;
    steps(5);
    chk("press_pre", {15'd0, btn_level[0]}, 16'd0);
    step();
    chk("press_lvl", {15'd0, btn_level[0]}, 16'd1);
    chk("press_pulse", {15'd0, btn_press[0]}, 16'd1);
    chk("press_kbd", kbd_data, 16'd130);
    step();
    chk("press_once", {15'd0, btn_press[0]}, 16'd0);
    btn = 3'b111;
    steps(5);
    chk("rel_pre", kbd_data, 16'd130);
    step();
    chk("rel_kbd", kbd_data, 16'd0);
    chk("rel_nopulse", {13'd0, btn_press}, 16'd0);
    steps(4);

    for (int r = 0; r < 5; r++) begin
      btn = 3'b101;
      steps(3);
      btn = 3'b111;
      step();
    end
    steps(6);
    chk("glitch_lvl", {13'd0, btn_level}, 16'd0);
    chk("glitch_kbd", kbd_data, 16'd0);

    btn = 3'b011;
    steps(6);
    chk("prio_nl", kbd_data, 16'd128);
    btn = 3'b010;
    steps(5);
    chk("prio_pre", kbd_data, 16'd128);
    step();
    chk("prio_left", kbd_data, 16'd130);
    btn = 3'b011;
    steps(5);
    chk("prio_hold", kbd_data, 16'd130);
    step();
    chk("prio_back", kbd_data, 16'd128);
    btn = 3'b111;
    steps(8);

    sw = 10'h2A5;
    steps(5);
    chk("sw_pre", {6'd0, sw_level}, 16'h000);
    step();
    chk("sw_new", {6'd0, sw_level}, 16'h2A5);
    sw = 10'h2A5 ^ 10'h008;
    steps(2);
    sw = 10'h2A5;
    steps(10);
    chk("sw_bounce", {6'd0, sw_level}, 16'h2A5);
    sw = 10'h000;
    steps(8);

    btn = 3'b101;
    steps(4);
    reset = 1'b0;
    steps(2);
    chk("midrst_kbd", kbd_data, 16'd0);
    chk("midrst_lvl", {13'd0, btn_level}, 16'd0);
    reset = 1'b1;
    lat    = -1;
    npress = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (btn_press[1]) begin
        npress++;
        if (lat < 0) lat = i;
      end
    end
    chk("midrst_lat", lat[15:0], 16'd6);
    chk("midrst_npress", npress[15:0], 16'd1);
    chk("midrst_kbd132", kbd_data, 16'd132);
    btn = 3'b111;
    steps(8);

    for (int s = 0; s < 200; s++) begin
      btn = 3'($urandom);
      if ($urandom_range(0, 2) == 0) sw = 10'($urandom);
      else sw = sw ^ (10'd1 << $urandom_range(0, 9));
      if ($urandom_range(0, 24) == 0) reset = 1'b0;
      len = $urandom_range(1, 7);
      steps(len);
      reset = 1'b1;
    end
    steps(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
